register_file_dump: RTL and testbench
=====================================

REGISTER_FILE_DUMP -- requirements
Module: register_file_dump

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning bits per register.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning address bits; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_reg_write, input, 1 bit: write enable.
REQ-006 The block SHALL have port i_write_register, input, ADDR_WIDTH bits: write address.
REQ-007 The block SHALL have port i_write_data, input, DATA_WIDTH bits: write data.
REQ-008 The block SHALL have ports i_read_register_1 and i_read_register_2, input, ADDR_WIDTH bits each: read addresses.
REQ-009 The block SHALL have ports o_read_data_1 and o_read_data_2, output, DATA_WIDTH bits each: registered read data.
REQ-010 The block SHALL have port i_dump_start, input, 1 bit: requests a full register dump.
REQ-011 The block SHALL have port i_dump_ready, input, 1 bit: consumer accepts the current dump word.
REQ-012 The block SHALL have port o_dump_valid, output, 1 bit: dump word valid.
REQ-013 The block SHALL have port o_dump_addr, output, ADDR_WIDTH bits: index of the current dump word.
REQ-014 The block SHALL have port o_dump_data, output, DATA_WIDTH bits: value of the current dump word.
REQ-015 The block SHALL have port o_dump_busy, output, 1 bit: high while FSM is not IDLE.
REQ-016 The block SHALL have port o_dump_done, output, 1 bit: one-cycle pulse after the last word is accepted.

Function
REQ-017 Writes SHALL commit at the rising edge where i_reg_write=1.
REQ-018 Each read port SHALL have 1-cycle latency: o_read_data_n <= registers[i_read_register_n] at the rising edge.
REQ-019 Same-cycle write bypass SHALL apply: if i_reg_write=1 and i_write_register==i_read_register_n, o_read_data_n SHALL load i_write_data.
REQ-020 Both read ports SHALL be independent; both may read the same address in the same cycle.
REQ-021 Dump FSM states SHALL be IDLE, STREAM and DONE.
- IDLE->STREAM on i_dump_start=1.
- STREAM->DONE on handshake at index DEPTH-1.
- DONE->IDLE unconditionally after one cycle.
REQ-022 On IDLE->STREAM, the block SHALL load o_dump_addr=0 and o_dump_data=registers[0] (with bypass per REQ-019), and set o_dump_valid=1 the next cycle.
REQ-023 A handshake (o_dump_valid && i_dump_ready) in STREAM below DEPTH-1 SHALL increment o_dump_addr and load o_dump_data from the new index (with bypass) in the same edge; o_dump_valid SHALL remain 1.
REQ-024 While o_dump_valid=1 and i_dump_ready=0, o_dump_addr and o_dump_data SHALL hold stable, even if the current register is written.
REQ-025 The handshake at index DEPTH-1 SHALL clear o_dump_valid, and o_dump_done SHALL be 1 for exactly the DONE cycle.
REQ-026 i_dump_start SHALL be ignored outside IDLE; o_dump_busy SHALL be 1 in STREAM and DONE.
REQ-027 Register writes SHALL remain fully functional during a dump; words not yet dumped SHALL reflect those writes.
REQ-028 o_dump_addr SHALL never wrap; a full dump SHALL emit exactly DEPTH words in ascending order.

Reset
REQ-029 While rst=0, the block SHALL asynchronously clear all registers, o_read_data_1/2, o_dump_addr, o_dump_data, o_dump_valid, o_dump_done and o_dump_busy to 0, and force the FSM to IDLE.
REQ-030 Reset asserted mid-dump SHALL abort the dump with no o_dump_done pulse; after release the FSM SHALL wait for a new i_dump_start.

Configuration
REQ-031 The block SHALL implement macro RF_ZERO_REG_EN as follows.
- Defined: writes to address 0 are discarded; reads and dump of address 0 return 0; bypass is suppressed for address 0.
- Undefined: register 0 is an ordinary register.

Verification
REQ-032 Write 0xDEADBEEF to r5, then read r5 on port 1 next cycle -> o_read_data_1=0xDEADBEEF one cycle later.
REQ-033 Write 0x12345678 to r7 while both ports read r7 in the same cycle -> both outputs =0x12345678 at the next edge.
REQ-034 RF_ZERO_REG_EN defined, write 0xFFFFFFFF to r0, read r0 -> 0; macro undefined -> 0xFFFFFFFF.
REQ-035 Preload rN=N*3, pulse i_dump_start with i_dump_ready=1 -> 32 words, addr 0..31, data N*3, then o_dump_done high for 1 cycle.
REQ-036 Dump with i_dump_ready=0 for 4 cycles at addr 3 while writing r3=0xAA -> addr and data hold the old r3; writing r9=0x55 during the stall -> word 9 shows 0x55.
REQ-037 Assert rst=0 at dump addr 10 -> all outputs 0 immediately, o_dump_done never pulses, all registers read 0 after release.

Source files
------------

// File: rtl/register_file_dump.sv
// Two-read/one-write register file with a streaming dump port (valid/ready).
// Reads: 1-cycle registered latency with same-cycle write bypass. Dump: one word per accepted handshake.
// Optional macro RF_ZERO_REG_EN: makes register 0 hard-wired to zero (writes dropped, no bypass).
module register_file_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_reg_write,
  input  logic [ADDR_WIDTH-1:0] i_write_register,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic [ADDR_WIDTH-1:0] i_read_register_1,
  input  logic [ADDR_WIDTH-1:0] i_read_register_2,
  output logic [DATA_WIDTH-1:0] o_read_data_1,
  output logic [DATA_WIDTH-1:0] o_read_data_2,
  input  logic                  i_dump_start,
  input  logic                  i_dump_ready,
  output logic                  o_dump_valid,
  output logic [ADDR_WIDTH-1:0] o_dump_addr,
  output logic [DATA_WIDTH-1:0] o_dump_data,
  output logic                  o_dump_busy,
  output logic                  o_dump_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr_en;
  logic                  handshake;
  logic [ADDR_WIDTH-1:0] addr_nxt;

`ifdef RF_ZERO_REG_EN
  // Register 0 never takes a write, which also keeps it out of the bypass path.
  assign wr_en = i_reg_write && (i_write_register != '0);
`else
  assign wr_en = i_reg_write;
`endif

  assign handshake = o_dump_valid && i_dump_ready;
  assign addr_nxt  = o_dump_addr + 1'b1;

  // Value a register will hold after this edge: the incoming write wins over the stored word.
  function automatic logic [DATA_WIDTH-1:0] fetch(input logic [ADDR_WIDTH-1:0] a);
`ifdef RF_ZERO_REG_EN
    if (a == '0) return '0;
`endif
    if (wr_en && (i_write_register == a)) return i_write_data;
    return regs[a];
  endfunction

  // Register array: cleared by reset, written on enabled edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[i_write_register] <= i_write_data;
    end
  end

  // Registered read ports with write bypass; the two ports are fully independent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_read_data_1 <= '0;
      o_read_data_2 <= '0;
    end else begin
      o_read_data_1 <= fetch(i_read_register_1);
      o_read_data_2 <= fetch(i_read_register_2);
    end
  end

  // Dump FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Dump FSM next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_dump_start) state_nxt = STREAM;
      STREAM:  if (handshake && (o_dump_addr == LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dump FSM status outputs decoded from the state.
  always_comb begin
    o_dump_busy = (state != IDLE);
    o_dump_done = (state == DONE);
  end

  // Dump word register: loads on start and on each accepted word, otherwise holds
  // so a stalled word stays stable even if its source register is rewritten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_dump_valid <= 1'b0;
      o_dump_addr  <= '0;
      o_dump_data  <= '0;
    end else begin
      if ((state == IDLE) && i_dump_start) begin
        o_dump_valid <= 1'b1;
        o_dump_addr  <= '0;
        o_dump_data  <= fetch('0);
      end else if ((state == STREAM) && handshake) begin
        if (o_dump_addr == LAST) begin
          o_dump_valid <= 1'b0;
        end else begin
          o_dump_addr <= addr_nxt;
          o_dump_data <= fetch(addr_nxt);
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file_dump.sv
// Scoreboard bench for register_file_dump: stimulus pushes expected read/dump results,
// a negedge monitor pops and compares when the DUT presents them.
module tb_register_file_dump;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

`ifdef RF_ZERO_REG_EN
  localparam logic [DW-1:0] R0_EXP = 32'h0000_0000;
`else
  localparam logic [DW-1:0] R0_EXP = 32'hFFFF_FFFF;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reg_write = 1'b0;
  logic [AW-1:0] write_register = '0;
  logic [DW-1:0] write_data = '0;
  logic [AW-1:0] read_register_1 = '0;
  logic [AW-1:0] read_register_2 = '0;
  logic [DW-1:0] read_data_1;
  logic [DW-1:0] read_data_2;
  logic          dump_start = 1'b0;
  logic          dump_ready = 1'b0;
  logic          dump_valid;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_busy;
  logic          dump_done;

  int errors = 0;
  int checks = 0;

  logic          rd_chk = 1'b0;
  logic          rd_chk_q = 1'b0;
  logic [DW-1:0] exp_rd1_q [$];
  logic [DW-1:0] exp_rd2_q [$];
  logic [AW-1:0] exp_daddr_q [$];
  logic [DW-1:0] exp_ddata_q [$];
  int            done_pending = 0;
  int            done_cnt = 0;

  register_file_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_reg_write       (reg_write),
    .i_write_register  (write_register),
    .i_write_data      (write_data),
    .i_read_register_1 (read_register_1),
    .i_read_register_2 (read_register_2),
    .o_read_data_1     (read_data_1),
    .o_read_data_2     (read_data_2),
    .i_dump_start      (dump_start),
    .i_dump_ready      (dump_ready),
    .o_dump_valid      (dump_valid),
    .o_dump_addr       (dump_addr),
    .o_dump_data       (dump_data),
    .o_dump_busy       (dump_busy),
    .o_dump_done       (dump_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one read on both ports this cycle, optionally alongside a write.
  task automatic rd_cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic [AW-1:0] a1, input logic [DW-1:0] e1,
                          input logic [AW-1:0] a2, input logic [DW-1:0] e2);
    reg_write = we; write_register = wa; write_data = wd;
    read_register_1 = a1; read_register_2 = a2;
    exp_rd1_q.push_back(e1);
    exp_rd2_q.push_back(e2);
    rd_chk = 1'b1;
    step();
    rd_chk = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic wr_cycle(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    reg_write = 1'b1; write_register = wa; write_data = wd;
    step();
    reg_write = 1'b0;
  endtask

  task automatic wait_addr(input logic [AW-1:0] a);
    for (int i = 0; i < 64; i++) begin
      if (dump_valid && dump_addr == a) break;
      step();
    end
    chk("reach_addr", {27'd0, dump_addr}, {27'd0, a});
  endtask

  task automatic wait_done(input string nm, input int prev);
    for (int i = 0; i < 200; i++) begin
      if (exp_daddr_q.size() == 0 && done_cnt == prev + 1) break;
      step();
    end
    chk({nm, "_done_cnt"}, done_cnt, prev + 1);
    chk({nm, "_words_left"}, exp_daddr_q.size(), 0);
  endtask

  always @(posedge clk) rd_chk_q <= rd_chk;

  // Monitor: compare read results, accepted dump words and done pulses against the queues.
  always @(negedge clk) begin
    if (rd_chk_q) begin
      if (exp_rd1_q.size() == 0) chk("rd_underflow", 1, 0);
      else begin
        chk("rd1", read_data_1, exp_rd1_q.pop_front());
        chk("rd2", read_data_2, exp_rd2_q.pop_front());
      end
    end
    if (dump_valid && dump_ready) begin
      if (exp_daddr_q.size() == 0) chk("dump_extra_word", {27'd0, dump_addr}, 32'hFFFF_FFFF);
      else begin
        chk("dump_addr", {27'd0, dump_addr}, {27'd0, exp_daddr_q.pop_front()});
        chk("dump_data", dump_data, exp_ddata_q.pop_front());
      end
    end
    if (dump_done) begin
      done_cnt++;
      chk("done_expected", (done_pending != 0), 1);
      if (done_pending > 0) done_pending--;
    end
  end

  task automatic push_word(input int n, input logic [DW-1:0] d);
    exp_daddr_q.push_back(AW'(n));
    exp_ddata_q.push_back(d);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rd1"}, read_data_1, 0);
    chk({nm, "_rd2"}, read_data_2, 0);
    chk({nm, "_valid"}, dump_valid, 0);
    chk({nm, "_addr"}, {27'd0, dump_addr}, 0);
    chk({nm, "_data"}, dump_data, 0);
    chk({nm, "_busy"}, dump_busy, 0);
    chk({nm, "_done"}, dump_done, 0);
  endtask

  initial begin
    int prev;
    // Reset state
    #2 rst = 1'b0;
    #2 chk_all_zero("reset");
    step(); step();
    rst = 1'b1;
    step();

    // Write r5 then read next cycle
    wr_cycle(5, 32'hDEAD_BEEF);
    rd_cycle(1'b0, 0, 0, 5, 32'hDEAD_BEEF, 5, 32'hDEAD_BEEF);

    // Bypass: write r7 while both ports read r7
    rd_cycle(1'b1, 7, 32'h1234_5678, 7, 32'h1234_5678, 7, 32'h1234_5678);
    // Independent ports on different addresses
    rd_cycle(1'b0, 0, 0, 7, 32'h1234_5678, 5, 32'hDEAD_BEEF);

    // Register 0 behaviour (bypass cycle, then stored value)
    rd_cycle(1'b1, 0, 32'hFFFF_FFFF, 0, R0_EXP, 5, 32'hDEAD_BEEF);
    rd_cycle(1'b0, 0, 0, 0, R0_EXP, 0, R0_EXP);

    // Preload rN = N*3
    for (int n = 0; n < DEPTH; n++) wr_cycle(AW'(n), DW'(n * 3));

    // Full dump with ready held high, with a stray start mid-stream
    for (int n = 0; n < DEPTH; n++) push_word(n, DW'(n * 3));
    done_pending++;
    prev = done_cnt;
    dump_ready = 1'b1;
    chk("idle_busy", dump_busy, 0);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    chk("stream_busy", dump_busy, 1);
    chk("first_valid", dump_valid, 1);
    step(); step();
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    wait_done("dump1", prev);
    step();
    chk("after_done_busy", dump_busy, 0);

    // Stall at word 3 while rewriting r3 and r9
    for (int n = 0; n < DEPTH; n++)
      push_word(n, (n == 3) ? 32'h9 : (n == 9) ? 32'h55 : DW'(n * 3));
    done_pending++;
    prev = done_cnt;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    wait_addr(3);
    dump_ready = 1'b0;
    wr_cycle(3, 32'hAA);
    wr_cycle(9, 32'h55);
    step(); step();
    chk("stall_addr", {27'd0, dump_addr}, 3);
    chk("stall_data", dump_data, 32'h9);
    chk("stall_valid", dump_valid, 1);
    dump_ready = 1'b1;
    wait_done("dump2", prev);

    // Reset mid-dump at word 10
    for (int n = 0; n < 10; n++)
      push_word(n, (n == 3) ? 32'hAA : (n == 9) ? 32'h55 : DW'(n * 3));
    step();
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    wait_addr(10);
    rst = 1'b0;
    #1 chk_all_zero("midreset");
    step(); step();
    rst = 1'b1;
    step(); step(); step();
    chk("abort_words_left", exp_daddr_q.size(), 0);
    chk("abort_busy", dump_busy, 0);
    chk("abort_valid", dump_valid, 0);
    for (int n = 0; n < DEPTH; n++) rd_cycle(1'b0, 0, 0, AW'(n), 0, AW'(DEPTH - 1 - n), 0);
    step(); step();
    chk("rd_queue_left", exp_rd1_q.size(), 0);
    chk("done_total", done_cnt, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
